// File: rtl/deco_sched.sv
// Round-robin scheduler sharing one Deco turbo-decoder among NREQ frame sources:
// grants a frame, streams it as WORD_W beats under start, then returns the tagged result.
module deco_sched #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 84,
  parameter int WORD_W  = 21,
  parameter int OUT_W   = 5,
  parameter int IDW     = 2,
  parameter int TMO_CYC = 1024
) (
  input  logic                    clk_p_i,
  input  logic                    reset_n_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*FRAME_W-1:0] req_frame_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [OUT_W-1:0]        rsp_data_o,
  output logic [IDW-1:0]          rsp_id_o,
  output logic                    rsp_err_o,
  output logic                    deco_start_o,
  output logic [WORD_W-1:0]       deco_data_o,
  input  logic [OUT_W-1:0]        deco_data_i,
  input  logic                    deco_done_i,
  output logic                    busy_o
);

  localparam int BEATS = FRAME_W / WORD_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int TW    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS);
  localparam logic [BW-1:0]  LAST_WORD = BW'(BEATS - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO_CYC - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     id_r;
  logic [FRAME_W-1:0] frame_r;
  logic [BW-1:0]      beat_r;
  logic [TW-1:0]      tmo_r;
  logic               start_r;
  logic [WORD_W-1:0]  data_r;
  logic               rsp_valid_r;
  logic [OUT_W-1:0]   rsp_data_r;
  logic [IDW-1:0]     rsp_id_r;
  logic               rsp_err_r;
  logic               busy_r;

  logic               gnt_hit_s;
  logic [IDW-1:0]     gnt_id_s;
  logic [IDW-1:0]     scan_idx_s;
  logic [FRAME_W-1:0] gnt_frame_s;
  logic [BW-1:0]      word_idx_s;
  logic [WORD_W-1:0]  next_word_s;

  // Round-robin pick: scan downward so the candidate closest to the pointer wins.
  always_comb begin
    gnt_hit_s  = 1'b0;
    gnt_id_s   = ptr_r;
    scan_idx_s = ptr_r;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx_s = IDW'((int'(ptr_r) + i) % NREQ);
      gnt_id_s   = req_valid_i[scan_idx_s] ? scan_idx_s : gnt_id_s;
      gnt_hit_s  = gnt_hit_s | req_valid_i[scan_idx_s];
    end
  end

  // Frame mux for the winning requester.
  always_comb begin
    gnt_frame_s = {FRAME_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      gnt_frame_s = (gnt_id_s == IDW'(k)) ? req_frame_i[k*FRAME_W +: FRAME_W] : gnt_frame_s;
    end
  end

  // Next beat word; the final extra beat repeats the last word.
  always_comb begin
    word_idx_s  = (beat_r >= LAST_WORD) ? LAST_WORD : beat_r + 1'b1;
    next_word_s = {WORD_W{1'b0}};
    for (int j = 0; j < BEATS; j++) begin
      next_word_s = (word_idx_s == BW'(j)) ? frame_r[j*WORD_W +: WORD_W] : next_word_s;
    end
  end

  // Accept pulse must follow the live valid so a withdrawn request is never taken.
  always_comb begin
    req_ready_o = {NREQ{1'b0}};
    if (state_r == GRANT && gnt_hit_s) begin
      req_ready_o[gnt_id_s] = 1'b1;
    end else begin
      req_ready_o = {NREQ{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_valid_i) state_nxt_s = GRANT;
        else              state_nxt_s = IDLE;
      end
      GRANT: begin
        if (gnt_hit_s) state_nxt_s = LOAD;
        else           state_nxt_s = IDLE;
      end
      LOAD: begin
        if (beat_r == LAST_BEAT) state_nxt_s = WAIT;
        else                     state_nxt_s = LOAD;
      end
      WAIT: begin
        if (deco_done_i || tmo_r == TMO_LAST) state_nxt_s = RESP;
        else                                   state_nxt_s = WAIT;
      end
      RESP: begin
        if (rsp_ready_i) state_nxt_s = IDLE;
        else             state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_nxt_s;
  end

  // Datapath, pointer and registered outputs.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r       <= {IDW{1'b0}};
      id_r        <= {IDW{1'b0}};
      frame_r     <= {FRAME_W{1'b0}};
      beat_r      <= {BW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      start_r     <= 1'b0;
      data_r      <= {WORD_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {OUT_W{1'b0}};
      rsp_id_r    <= {IDW{1'b0}};
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      case (state_r)
        GRANT: begin
          if (gnt_hit_s) begin
            frame_r <= gnt_frame_s;
            id_r    <= gnt_id_s;
            ptr_r   <= (gnt_id_s == LAST_ID) ? {IDW{1'b0}} : gnt_id_s + 1'b1;
            start_r <= 1'b1;
            data_r  <= gnt_frame_s[WORD_W-1:0];
            beat_r  <= {BW{1'b0}};
          end
        end
        LOAD: begin
          beat_r <= beat_r + 1'b1;
          if (beat_r == LAST_BEAT) begin
            start_r <= 1'b0;
            tmo_r   <= {TW{1'b0}};
          end else begin
            data_r <= next_word_s;
          end
        end
        WAIT: begin
          if (deco_done_i) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= deco_data_i;
            rsp_id_r    <= id_r;
            rsp_err_r   <= 1'b0;
          end else if (tmo_r == TMO_LAST) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= {OUT_W{1'b0}};
            rsp_id_r    <= id_r;
            rsp_err_r   <= 1'b1;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) rsp_valid_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_data_o   = rsp_data_r;
  assign rsp_id_o     = rsp_id_r;
  assign rsp_err_o    = rsp_err_r;
  assign deco_start_o = start_r;
  assign deco_data_o  = data_r;
  assign busy_o       = busy_r;

endmodule
